// File: rtl/dwconv2d_dispatch.sv
// dwconv2d_dispatch: buffers tagged convolution descriptors in a small FIFO,
// issues them one at a time to the dwconv2d engine (start/ready/done) and
// returns each result with its tag over a valid/ready response port.
// Optional watchdog on the engine: define DWCONV2D_DISPATCH_TIMEOUT_EN.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for a queued command and an idle engine
// S_ISSUE     | one-cycle start pulse, descriptor registers valid
// S_WAIT_DONE | engine running; done ignored on the first cycle
// S_RESPOND   | response held until the consumer accepts it

module dwconv2d_dispatch #(
    parameter int DEPTH          = 4,
    parameter int TAG_W          = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [31:0]              cmd_input_ptr,
    input  logic [31:0]              cmd_filter_ptr,
    input  logic [31:0]              cmd_output_ptr,
    input  logic [31:0]              cmd_input_dims,
    input  logic [31:0]              cmd_filter_dims,
    input  logic [31:0]              cmd_output_dims,
    input  logic [31:0]              cmd_stride,
    input  logic [31:0]              cmd_padding,
    input  logic [TAG_W-1:0]         cmd_tag,
    output logic                     unit_start,
    output logic [31:0]              unit_input_ptr,
    output logic [31:0]              unit_filter_ptr,
    output logic [31:0]              unit_output_ptr,
    output logic [31:0]              unit_input_dims,
    output logic [31:0]              unit_filter_dims,
    output logic [31:0]              unit_output_dims,
    output logic [31:0]              unit_stride,
    output logic [31:0]              unit_padding,
    input  logic [31:0]              unit_result,
    input  logic                     unit_done,
    input  logic                     unit_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_result,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     rsp_timeout,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   pending_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int FW  = 8 * 32;
    localparam int DW  = FW + TAG_W;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dwconv2d_dispatch: DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("dwconv2d_dispatch: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_RESPOND   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  mem_q [DEPTH];
    logic [DW-1:0]  mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [FW-1:0]  desc_q, desc_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]    result_q, result_d;
    logic           first_q, first_d;
    logic           push;
    logic           pop;
    logic [DW-1:0]  cmd_word;
    logic [DW-1:0]  head_word;

`ifdef DWCONV2D_DISPATCH_TIMEOUT_EN
    // Watchdog is a down-counter loaded on WAIT_DONE entry; expiry on the
    // TIMEOUT_CYCLES-th WAIT_DONE cycle when it has reached zero.
    localparam logic [31:0] TMR_LOAD = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0]    tmr_q, tmr_d;
    logic           timeout_q, timeout_d;
`endif

    assign cmd_word  = {cmd_tag, cmd_padding, cmd_stride, cmd_output_dims,
                        cmd_filter_dims, cmd_input_dims, cmd_output_ptr,
                        cmd_filter_ptr, cmd_input_ptr};
    assign head_word = mem_q[rd_ptr_q];

    // Ready depends on registered count only: a full FIFO stays full for the pop cycle.
    assign cmd_ready = (count_q != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;

    assign unit_start       = (state_q == S_ISSUE);
    assign unit_input_ptr   = desc_q[0*32 +: 32];
    assign unit_filter_ptr  = desc_q[1*32 +: 32];
    assign unit_output_ptr  = desc_q[2*32 +: 32];
    assign unit_input_dims  = desc_q[3*32 +: 32];
    assign unit_filter_dims = desc_q[4*32 +: 32];
    assign unit_output_dims = desc_q[5*32 +: 32];
    assign unit_stride      = desc_q[6*32 +: 32];
    assign unit_padding     = desc_q[7*32 +: 32];

    assign rsp_valid     = (state_q == S_RESPOND);
    assign rsp_result    = result_q;
    assign rsp_tag       = tag_q;
    assign busy          = (state_q != S_IDLE) || (count_q != '0);
    assign pending_count = count_q;

`ifdef DWCONV2D_DISPATCH_TIMEOUT_EN
    assign rsp_timeout = timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    // FIFO storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = cmd_word;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Issue FSM: next state, descriptor capture and response capture.
    always_comb begin
        state_d  = state_q;
        desc_d   = desc_q;
        tag_d    = tag_q;
        result_d = result_q;
        first_d  = 1'b0;
        pop      = 1'b0;
`ifdef DWCONV2D_DISPATCH_TIMEOUT_EN
        tmr_d     = tmr_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0 && unit_ready) begin
                    pop     = 1'b1;
                    desc_d  = head_word[FW-1:0];
                    tag_d   = head_word[DW-1:FW];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                first_d = 1'b1;
                state_d = S_WAIT_DONE;
`ifdef DWCONV2D_DISPATCH_TIMEOUT_EN
                tmr_d = TMR_LOAD;
`endif
            end
            S_WAIT_DONE: begin
`ifdef DWCONV2D_DISPATCH_TIMEOUT_EN
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end
`endif
                // Done wins over a coincident watchdog expiry.
                if (!first_q && unit_done) begin
                    result_d = unit_result;
                    state_d  = S_RESPOND;
`ifdef DWCONV2D_DISPATCH_TIMEOUT_EN
                    timeout_d = 1'b0;
                end else if (tmr_q == '0) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = S_RESPOND;
`endif
                end
            end
            S_RESPOND: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, FIFO and descriptor registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            desc_q   <= '0;
            tag_q    <= '0;
            result_q <= '0;
            first_q  <= 1'b0;
`ifdef DWCONV2D_DISPATCH_TIMEOUT_EN
            tmr_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            desc_q   <= desc_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            first_q  <= first_d;
`ifdef DWCONV2D_DISPATCH_TIMEOUT_EN
            tmr_q     <= tmr_d;
            timeout_q <= timeout_d;
`endif
        end
    end

endmodule

// File: doc/dwconv2d_dispatch.md
# dwconv2d_dispatch

Command-side initiator for the depthwise-convolution unit. Accepts tagged convolution descriptors from the softcore over a valid/ready push interface and buffers them in a small FIFO. Issues them one at a time to the `dwconv2d` engine using its start/ready/done handshake. Returns each engine result, with its tag, over a valid/ready response interface. Sits between the softcore's command path and the convolution engine.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, 2..16.
- `TAG_W`, 8: width of the opaque command tag.
- `TIMEOUT_CYCLES`, 65535: watchdog limit, used only with the timeout feature.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO not full.
- `cmd_input_ptr`, `cmd_filter_ptr`, `cmd_output_ptr` in 32 each: buffer pointers.
- `cmd_input_dims`, `cmd_filter_dims`, `cmd_output_dims`, `cmd_stride`, `cmd_padding` in 32 each: packed engine fields, passed through unmodified.
- `cmd_tag` in TAG_W: returned with the response.
- `unit_start` out 1: one-cycle start pulse to the engine.
- `unit_input_ptr`, `unit_filter_ptr`, `unit_output_ptr`, `unit_input_dims`, `unit_filter_dims`, `unit_output_dims`, `unit_stride`, `unit_padding` out 32 each: registered descriptor fields.
- `unit_result` in 32: engine result.
- `unit_done` in 1: engine completion.
- `unit_ready` in 1: engine idle.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: response accepted.
- `rsp_result` out 32: captured result.
- `rsp_tag` out TAG_W: tag of the completed command.
- `rsp_timeout` out 1: command aborted by the watchdog.
- `busy` out 1: FSM is not in IDLE, or the FIFO is non-empty.
- `pending_count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **FIFO.** Push when `cmd_valid && cmd_ready`. `cmd_ready = (count != DEPTH)`. This is computed from registered count only, so a pop in the same cycle does not free a slot when full. The FIFO holds the full 8×32+TAG_W descriptor.
- **IDLE.** If the FIFO is non-empty and `unit_ready==1`:
  - pop the head into the descriptor registers that drive `unit_*` fields and the held tag;
  - go to ISSUE.
- **ISSUE.** Assert `unit_start=1` for this cycle only; go to WAIT_DONE.
- **WAIT_DONE.**
  - `unit_done` is ignored on the first WAIT_DONE cycle.
  - On any later cycle with `unit_done==1`: capture `unit_result` into `rsp_result`, set `rsp_timeout=0`, set `rsp_valid=1`, go to RESPOND.
- **RESPOND.** Hold `rsp_*` stable until `rsp_valid && rsp_ready`. Then clear `rsp_valid` and go to IDLE.
- **Descriptor stability.** `unit_*` fields stay stable from ISSUE through the end of WAIT_DONE. They change only on the next pop.
- **Ordering.** Only one command is outstanding at a time. Responses return in command order.
- **Reset values.** All outputs are 0 except `cmd_ready=1`. This covers `unit_start`, all `unit_*` fields, `rsp_valid`, `rsp_result`, `rsp_tag`, `rsp_timeout`, `busy` and `pending_count`. The FIFO is emptied and the FSM returns to IDLE.
- **Reset mid-operation.** Asserting `rst_n` low mid-operation drops the in-flight command and all queued commands. No response is generated for them. The engine shares `rst_n`.

## Timing
- Push to `unit_start`, with the FIFO empty, FSM idle and `unit_ready=1`: push lands at edge N, pop at edge N+1, `unit_start` high during cycle N+1 to N+2.
- `unit_done` high in cycle D produces `rsp_valid` high from edge D+1.
- Handshake in cycle R: the next pop can occur at edge R+2, at the earliest.
- `unit_ready==0` in IDLE stalls the pop indefinitely. The FIFO keeps accepting commands while not full.
- Simultaneous push and pop with `0<count<DEPTH`: count is unchanged and data order is preserved.

## Configuration
- **`DWCONV2D_DISPATCH_TIMEOUT_EN` defined:**
  - A 32-bit counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - When the counter reaches `TIMEOUT_CYCLES` without `unit_done`: go to RESPOND with `rsp_timeout=1`, `rsp_result=0` and the held tag.
  - If `unit_done` and the limit coincide, done wins and `rsp_timeout=0`.
- **Undefined:** no counter; WAIT_DONE waits forever; `rsp_timeout` is tied to 0.

## Test plan
- Single command, tag 0x5A, engine model returns 0x0000_0009 after 5 cycles. Expect:
  - one-cycle `unit_start`;
  - fields equal the pushed values;
  - response `{0x9, 0x5A, timeout=0}`.
- Push 5 commands back-to-back with DEPTH=4 and the engine held busy. Expect `cmd_ready` low after 4 and `pending_count=4`. Then release; responses arrive in order with tags 0..4.
- Hold `rsp_ready=0` for 10 cycles. Expect `rsp_*` stable and no further `unit_start` until accepted.
- Hold `unit_ready=0` in IDLE with 2 queued commands. Expect no `unit_start`. Raise it; issue starts the next cycle.
- Assert `rst_n` low during WAIT_DONE with 3 queued. Expect all outputs at reset values immediately and `pending_count=0`. No response after release.
- With `DWCONV2D_DISPATCH_TIMEOUT_EN` and `TIMEOUT_CYCLES=20`, the engine never asserts done. Expect response `{0, tag, timeout=1}` 20 cycles after WAIT_DONE entry. Without the macro, no response.
